// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for one modulo up/down counter instance.
// master drives controls and observes the count; slave is the counter itself.
interface mod_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             up;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             terminal;
   logic             carry_out;
   logic             wrapped;

   modport master (
      output enable, up, clear, load, load_value,
      input  count, terminal, carry_out, wrapped
   );

   modport slave (
      input  enable, up, clear, load, load_value,
      output count, terminal, carry_out, wrapped
   );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with clear/load, wrap-or-saturate ends and a cascade carry.
// Latency: 1 clk from enable to new count; terminal/carry_out combinational; no backpressure.
module mod_updown_counter #(
   parameter int              WIDTH       = 8,
   parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
   parameter longint unsigned RESET_VALUE = 64'd0,
   parameter int              SATURATE    = 0
) (
   input  logic                clk,
   input  logic                resetn,
   mod_updown_counter_if.slave cnt
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be 1..32");
   end
   if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must be 2..2**WIDTH");
   end
   if (RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("mod_updown_counter: RESET_VALUE must be below MODULUS");
   end
   if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
      $error("mod_updown_counter: SATURATE must be 0 or 1");
   end

   // Range end held one bit wider so MODULUS = 2**WIDTH still compares cleanly.
   localparam logic [WIDTH:0]   LAST_W = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] LAST_N = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] RST_N  = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrapped_q;
   logic             wrapped_d;
   logic [WIDTH:0]   cnt_x;
   logic             at_last;
   logic             at_zero;
   logic             terminal;

   assign cnt_x    = {1'b0, count_q};
   assign at_last  = (cnt_x == LAST_W);
   assign at_zero  = (count_q == '0);
   assign terminal = cnt.up ? at_last : at_zero;

   always_comb begin
      count_d   = count_q;
      wrapped_d = 1'b0;
      if (cnt.clear) begin
         count_d = RST_N;
      end else if (cnt.load) begin
         // Out-of-range loads clamp to the top of the range rather than aliasing.
         if ({1'b0, cnt.load_value} > LAST_W) begin
            count_d = LAST_N;
         end else begin
            count_d = cnt.load_value;
         end
      end else if (cnt.enable) begin
         if (cnt.up) begin
            if (!at_last) begin
               count_d = WIDTH'(cnt_x + ONE_W);
            end else if (SATURATE == 0) begin
               count_d   = '0;
               wrapped_d = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               count_d = WIDTH'(cnt_x - ONE_W);
            end else if (SATURATE == 0) begin
               count_d   = LAST_N;
               wrapped_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q   <= RST_N;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
      end
   end

   // Carry flags the limit even when saturating so a downstream stage still advances.
   assign cnt.count     = count_q;
   assign cnt.terminal  = terminal;
   assign cnt.carry_out = cnt.enable & terminal & ~cnt.clear & ~cnt.load;
   assign cnt.wrapped   = wrapped_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboarded bench: wrap/saturate counters plus a 10x6 cascade, directed vectors.
module tb_mod_updown_counter;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mod_updown_counter_if #(.WIDTH(4)) a_if ();
   mod_updown_counter_if #(.WIDTH(4)) s_if ();
   mod_updown_counter_if #(.WIDTH(4)) c1_if ();
   mod_updown_counter_if #(.WIDTH(4)) c2_if ();

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(0))
      u_a  (.clk(clk), .resetn(resetn), .cnt(a_if));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(1))
      u_s  (.clk(clk), .resetn(resetn), .cnt(s_if));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(0))
      u_c1 (.clk(clk), .resetn(resetn), .cnt(c1_if));
   mod_updown_counter #(.WIDTH(4), .MODULUS(6), .RESET_VALUE(0), .SATURATE(0))
      u_c2 (.clk(clk), .resetn(resetn), .cnt(c2_if));

   assign c2_if.enable = c1_if.carry_out;

   typedef struct {
      string tag;
      int    id;
      int    count;
      int    wrapped;
      int    terminal;
      int    carry;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   act_c, act_w, act_t, act_co;

   function automatic void push(string tag, int id, int c, int w, int t, int co);
      exp_t e;
      e.tag = tag; e.id = id; e.count = c; e.wrapped = w; e.terminal = t; e.carry = co;
      sb.push_back(e);
   endfunction

   function automatic void check(string tag, string field, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
      end
   endfunction

   // Inputs change 1 time unit after posedge, so negedge sees the settled count
   // together with the combinational outputs for the inputs just applied.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         cur = sb.pop_front();
         case (cur.id)
            0: begin act_c = int'(a_if.count);  act_w = int'(a_if.wrapped);
                     act_t = int'(a_if.terminal); act_co = int'(a_if.carry_out); end
            1: begin act_c = int'(s_if.count);  act_w = int'(s_if.wrapped);
                     act_t = int'(s_if.terminal); act_co = int'(s_if.carry_out); end
            2: begin act_c = int'(c1_if.count); act_w = int'(c1_if.wrapped);
                     act_t = int'(c1_if.terminal); act_co = int'(c1_if.carry_out); end
            default: begin act_c = int'(c2_if.count); act_w = int'(c2_if.wrapped);
                     act_t = int'(c2_if.terminal); act_co = int'(c2_if.carry_out); end
         endcase
         check(cur.tag, "count", act_c, cur.count);
         check(cur.tag, "wrapped", act_w, cur.wrapped);
         check(cur.tag, "terminal", act_t, cur.terminal);
         check(cur.tag, "carry_out", act_co, cur.carry);
      end
   end

   task automatic step_a(input bit en, input bit up, input bit clr, input bit ld, input int lv,
                         input string tag, input int c, input int w, input int t, input int co);
      a_if.enable = en; a_if.up = up; a_if.clear = clr; a_if.load = ld; a_if.load_value = 4'(lv);
      push(tag, 0, c, w, t, co);
      @(posedge clk); #1;
   endtask

   task automatic step_s(input bit en, input bit up, input string tag,
                         input int c, input int w, input int t, input int co);
      s_if.enable = en; s_if.up = up;
      push(tag, 1, c, w, t, co);
      @(posedge clk); #1;
   endtask

   int t1_cnt [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int t3_up  [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9, 9, 9};
   int t3_dn  [12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      a_if.enable = 0; a_if.up = 0; a_if.clear = 0; a_if.load = 0; a_if.load_value = '0;
      s_if.enable = 0; s_if.up = 0; s_if.clear = 0; s_if.load = 0; s_if.load_value = '0;
      c1_if.enable = 0; c1_if.up = 1; c1_if.clear = 0; c1_if.load = 0; c1_if.load_value = '0;
      c2_if.up = 1; c2_if.clear = 0; c2_if.load = 0; c2_if.load_value = '0;
      @(posedge clk); #1;

      // Reset held while enabled: count stays at reset value.
      for (int i = 0; i < 5; i++) step_a(1, 1, 0, 0, 0, "t1_reset", 0, 0, 0, 0);
      resetn = 1'b1;
      for (int i = 0; i < 12; i++)
         step_a(1, 1, 0, 0, 0, "t1_up", t1_cnt[i], (i == 10) ? 1 : 0,
                (i == 9) ? 1 : 0, (i == 9) ? 1 : 0);

      // Count down through zero.
      step_a(1, 0, 0, 0, 0, "t2_dn2", 2, 0, 0, 0);
      step_a(1, 0, 0, 0, 0, "t2_dn1", 1, 0, 0, 0);
      step_a(1, 0, 0, 0, 0, "t2_dn0", 0, 0, 1, 1);
      step_a(1, 0, 0, 0, 0, "t2_dn9", 9, 1, 0, 0);
      step_a(0, 0, 0, 0, 0, "t2_hold", 8, 0, 0, 0);

      // Load, clamp, clear-over-load, wrap after a load.
      step_a(1, 1, 0, 1, 6,  "t4_ld6",     8, 0, 0, 0);
      step_a(1, 1, 0, 1, 13, "t4_ld13",    6, 0, 0, 0);
      step_a(1, 1, 1, 1, 3,  "t4_clr_ld",  9, 0, 1, 0);
      step_a(1, 1, 0, 0, 0,  "t4_cleared", 0, 0, 0, 0);
      step_a(0, 1, 0, 1, 9,  "t4_ld9",     1, 0, 0, 0);
      step_a(1, 1, 0, 0, 0,  "t4_at9",     9, 0, 1, 1);
      step_a(0, 1, 0, 1, 7,  "t4_ld7",     0, 1, 0, 0);
      step_a(0, 0, 0, 0, 0,  "t4_hold7",   7, 0, 0, 0);

      // Asynchronous reset mid-cycle: seen at negedge, before any clock edge.
      resetn = 1'b0;
      step_a(0, 1, 0, 0, 0, "t5_async", 0, 0, 0, 0);
      resetn = 1'b1;
      step_a(1, 1, 0, 0, 0, "t5_resume0", 0, 0, 0, 0);
      step_a(1, 1, 0, 0, 0, "t5_resume1", 1, 0, 0, 0);
      step_a(0, 1, 0, 0, 0, "t5_resume2", 2, 0, 0, 0);

      // Saturating instance.
      for (int i = 0; i < 15; i++)
         step_s(1, 1, "t3_sat_up", t3_up[i], 0, (t3_up[i] == 9) ? 1 : 0, (t3_up[i] == 9) ? 1 : 0);
      for (int i = 0; i < 12; i++)
         step_s(1, 0, "t3_sat_dn", t3_dn[i], 0, (t3_dn[i] == 0) ? 1 : 0, (t3_dn[i] == 0) ? 1 : 0);
      step_s(0, 0, "t3_idle_dn", 0, 0, 1, 0);
      step_s(0, 1, "t3_idle_up", 0, 0, 0, 0);

      // Cascade: 10 x 6 over 60 enabled cycles.
      c1_if.enable = 1'b1;
      for (int k = 0; k < 60; k++) begin
         push("t6_c1", 2, k % 10, (k > 0 && k % 10 == 0) ? 1 : 0,
              (k % 10 == 9) ? 1 : 0, (k % 10 == 9) ? 1 : 0);
         push("t6_c2", 3, k / 10, 0, (k / 10 == 5) ? 1 : 0, (k == 59) ? 1 : 0);
         @(posedge clk); #1;
      end
      c1_if.enable = 1'b0;
      push("t6_c1_end", 2, 0, 1, 0, 0);
      push("t6_c2_end", 3, 0, 1, 0, 0);
      @(posedge clk); #1;

      @(negedge clk); #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
